// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution block: funct3 encodings,
// controller states and the default flush length.
package branch_pkg;

  localparam int FLUSH_CYCLES_DEF = 2;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EVAL     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator; funct3 values outside the
// six conditional branches report illegal and never report taken.
module branch_cmp
  import branch_pkg::*;
(
  input  logic [2:0]  fn3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        taken,
  output logic        illegal
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (fn3)
      F3_BEQ:  taken = (a == b);
      F3_BNE:  taken = (a != b);
      F3_BLT:  taken = (a_s < b_s);
      F3_BGE:  taken = (a_s >= b_s);
      F3_BLTU: taken = (a < b);
      F3_BGEU: taken = (a >= b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: captures one branch, evaluates it, then
// issues a redirect strobe and a fixed-length flush when it is taken.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_fn3,
  input  logic [31:0] br_rs1,
  input  logic [31:0] br_rs2,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_imm,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        fault,
  output logic [15:0] br_count,
  output logic [15:0] taken_count
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  flush_cnt_q;
  logic [15:0] br_count_q;
  logic [15:0] taken_count_q;
  logic [31:0] redirect_pc_q;

  logic [2:0]  fn3_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] pc_q;
  logic [31:0] imm_q;

  logic        cmp_taken;
  logic        cmp_illegal;
  logic [31:0] target_d;
  logic        misaligned;
  logic        redirect_d;

  branch_cmp u_cmp (
    .fn3     (fn3_q),
    .a       (rs1_q),
    .b       (rs2_q),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  assign target_d   = pc_q + imm_q;
  assign misaligned = (target_d[1:0] != 2'b00);
  assign redirect_d = !cmp_illegal && cmp_taken && !misaligned;

  // Operand capture carries no reset; it only matters once EVAL is entered.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_IDLE && br_valid) begin
      fn3_q <= br_fn3;
      rs1_q <= br_rs1;
      rs2_q <= br_rs2;
      pc_q  <= br_pc;
      imm_q <= br_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      flush_cnt_q   <= 4'd0;
      br_count_q    <= 16'd0;
      taken_count_q <= 16'd0;
      redirect_pc_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (br_valid) state_q <= ST_EVAL;
        end
        ST_EVAL: begin
          if (!cmp_illegal) br_count_q <= br_count_q + 16'd1;
          if (redirect_d) begin
            taken_count_q <= taken_count_q + 16'd1;
            redirect_pc_q <= target_d;
            state_q       <= ST_REDIRECT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REDIRECT: begin
          flush_cnt_q <= FLUSH_LOAD;
          state_q     <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (flush_cnt_q == 4'd0) state_q <= ST_IDLE;
          else flush_cnt_q <= flush_cnt_q - 4'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Reset gates the strobes so the idle values show while reset is still held.
  assign br_ready       = reset || (state_q == ST_IDLE);
  assign stall          = !br_ready;
  assign redirect_valid = !reset && (state_q == ST_REDIRECT);
  assign flush          = !reset && (state_q == ST_FLUSH);
  assign fault          = !reset && (state_q == ST_EVAL) &&
                          (cmp_illegal || (cmp_taken && misaligned));
  assign redirect_pc    = reset ? 32'd0 : redirect_pc_q;
  assign br_count       = br_count_q;
  assign taken_count    = taken_count_q;

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: pipeline flush duration in cycles after a taken redirect; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 br_valid  input  1  branch request present.
REQ-005 br_ready  output  1  block can accept a request.
REQ-006 br_fn3  input  3  branch funct3.
REQ-007 br_rs1, br_rs2  input  32 each  compare operands.
REQ-008 br_pc, br_imm  input  32 each  branch PC and sign-extended offset.
REQ-009 stall  output  1  hold upstream stages.
REQ-010 redirect_valid  output  1  one-cycle fetch redirect strobe.
REQ-011 redirect_pc  output  32  redirect target.
REQ-012 flush  output  1  squash younger instructions.
REQ-013 fault  output  1  one-cycle strobe for an illegal funct3 or misaligned target.
REQ-014 br_count, taken_count  output  16 each  resolved and taken branch counters.

Function
REQ-015 States: IDLE, EVAL, REDIRECT, FLUSH.
REQ-016 br_ready = 1 only in IDLE; stall = 1 in every state other than IDLE.
REQ-017 Handshake: in IDLE with br_valid=1, capture br_fn3, br_rs1, br_rs2, br_pc and br_imm, then go to EVAL; inputs are ignored outside IDLE.
REQ-018 EVAL lasts one cycle and decodes the captured fn3 as follows.
- 000: beq, equal.
- 001: bne, not equal.
- 100: blt, signed less-than.
- 101: bge, signed greater-or-equal.
- 110: bltu, unsigned less-than.
- 111: bgeu, unsigned greater-or-equal.
REQ-019 Target = br_pc + br_imm, modulo 2^32; wrap-around is not an error.
REQ-020 In EVAL with fn3 010 or 011: fault=1 for that cycle, branch treated as not taken, next state IDLE.
REQ-021 In EVAL, taken with target[1:0] != 0: fault=1, no redirect, next state IDLE.
REQ-022 In EVAL, not taken (legal fn3): next state IDLE, no redirect.
REQ-023 In EVAL, taken with an aligned target: next state REDIRECT.
REQ-024 REDIRECT lasts one cycle: redirect_valid=1, redirect_pc=target, then go to FLUSH.
REQ-025 FLUSH holds flush=1 for exactly FLUSH_CYCLES cycles, counted by a down-counter, then returns to IDLE.
REQ-026 Latency: accept in cycle N, EVAL in N+1, redirect in N+2, flush in N+3..N+2+FLUSH_CYCLES, next accept no earlier than N+3+FLUSH_CYCLES.
REQ-027 Not-taken latency: accept in N, next accept no earlier than N+2.
REQ-028 br_count increments once per EVAL with a legal fn3; taken_count increments once per EVAL that enters REDIRECT; both wrap at 2^16.
REQ-029 redirect_pc holds its last value when redirect_valid=0.
REQ-030 redirect_valid, flush and fault are never asserted in IDLE.

Reset
REQ-031 reset=1 at a clock edge forces state IDLE and clears the flush counter, br_count and taken_count, from any state including mid-REDIRECT and mid-FLUSH.
REQ-032 Outputs during and immediately after reset: br_ready=1, stall=0, redirect_valid=0, flush=0, fault=0, redirect_pc=0.
REQ-033 When reset and br_valid are asserted together, no request is captured.

Structure
REQ-034 Shared package branch_pkg holds:
- funct3 encodings.
- State enumeration.
- FLUSH_CYCLES default value.
REQ-035 Compare logic lives in combinational sub-module branch_cmp, with inputs fn3, a and b and outputs taken and illegal.

Verification
REQ-036 beq 5,5 at PC 0x100, imm 0x20 -> redirect_valid at N+2 with redirect_pc=0x120, flush high for 2 cycles, taken_count=1.
REQ-037 blt rs1=0xFFFFFFFF, rs2=1 -> taken; bltu with the same operands -> not taken, br_ready back at N+2, br_count=2.
REQ-038 fn3=010 -> fault pulse at N+1, no redirect, br_count unchanged.
REQ-039 Taken bne with PC 0x100 and imm 0x2 -> fault at N+1, no redirect; taken beq with PC 0xFFFFFFF0 and imm 0x20 -> redirect_pc=0x10.
REQ-040 Reset asserted during the first FLUSH cycle -> flush=0 and br_ready=1 on the next cycle, counters zero.
REQ-041 br_valid held high across back-to-back taken branches -> second capture no earlier than N+5 with FLUSH_CYCLES=2.
